// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   OVERSAMPLE     - s_tick pulses per bit period
//   PAR_*          - parity mode encodings for the PARITY parameter
//   tx_state_t     - one-hot transmitter state encoding
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter. One byte per accepted tx_start is
// sent as start bit, NB_DATA data bits LSB first, optional parity bit and a
// stop period of SB_TICK s_ticks. Bit timing comes from the 16x s_tick.
//   clk, reset    - clock, synchronous active-high reset
//   s_tick        - one-cycle pulse at 16x baud
//   tx_start      - send request, honoured only in IDLE
//   tx_data       - byte captured on the accepted tx_start
//   tx_done_tick  - one-cycle pulse in the cycle after the stop period ends
//   tx_busy       - frame in progress
//   tx            - registered serial line, idles high
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               tx_start,
    input  logic [NB_DATA-1:0] tx_data,
    output logic               tx_done_tick,
    output logic               tx_busy,
    output logic               tx
);

    // Tick counter must hold both 0..15 and 0..SB_TICK-1.
    localparam int TW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);

    tx_state_t          state;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] shreg_nxt;
    logic               par_bit;

    assign shreg_nxt = shreg >> 1;

    // tx is loaded with the value of the state being entered, so the line
    // changes on the same edge as the state and stays a pure register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        shreg    <= tx_data;
                        par_bit  <= (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_DATA;
                            tx       <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg_nxt;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (PARITY != PAR_NONE) begin
                                    state <= ST_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shreg_nxt[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt     <= '0;
                            state        <= ST_IDLE;
                            tx           <= 1'b1;
                            tx_busy      <= 1'b0;
                            tx_done_tick <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // Illegal one-hot value: drop the frame and park in IDLE.
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Three instances: defaults,
// even parity with 2 stop bits, odd parity with 2 stop bits. Stimulus pushes
// the hand-computed line pattern of each frame; a monitor per instance pops
// it when that instance's line falls and checks every cycle of the frame.
module tb_uart_tx;

    typedef struct {
        int          inst;
        logic [15:0] bits;     // slot 0 = start bit, then data, then parity
        int          nslots;
        int          bitcyc;   // clk cycles per bit slot
        int          stopcyc;  // clk cycles of stop level
        int          cut;      // cycle index where reset aborts, -1 = none
    } exp_t;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic [7:0] tx_data;
    logic       start_v [3];
    logic       tx_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   ndone  [3] = '{0, 0, 0};
    int   per    = 1;
    int   tdiv   = 0;
    exp_t sb[$];

    uart_tx #(.NB_DATA(8), .SB_TICK(16), .PARITY(0)) u_def (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[0]),
        .tx_data(tx_data), .tx_done_tick(done_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));

    uart_tx #(.NB_DATA(8), .SB_TICK(32), .PARITY(1)) u_even (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[1]),
        .tx_data(tx_data), .tx_done_tick(done_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));

    uart_tx #(.NB_DATA(8), .SB_TICK(32), .PARITY(2)) u_odd (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_v[2]),
        .tx_data(tx_data), .tx_done_tick(done_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // s_tick: one cycle high out of every 'per', updated just after posedge.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv   = (tdiv + 1 >= per) ? 0 : tdiv + 1;
            s_tick = (tdiv == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (done_w[k] === 1'b1) ndone[k]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor(input int k);
        exp_t e;
        int   total, dcyc, slot;
        bit   slot_ok, aborted;
        logic expb;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_w[k] === 1'b0) begin
                if (sb.size() == 0 || sb[0].inst != k) begin
                    check(1'b0, $sformatf("i%0d_unexpected_frame", k), 0, 1);
                    for (int w = 0; w < 2000 && tx_w[k] !== 1'b1; w++) @(negedge clk);
                end else begin
                    e       = sb.pop_front();
                    dcyc    = e.nslots * e.bitcyc;
                    total   = dcyc + e.stopcyc;
                    slot_ok = 1'b1;
                    aborted = 1'b0;
                    for (int i = 0; i < total; i++) begin
                        if (i > 0) @(negedge clk);
                        if (e.cut >= 0 && i == e.cut) begin
                            check(tx_w[k] === 1'b1 && busy_w[k] === 1'b0 && done_w[k] === 1'b0,
                                  $sformatf("i%0d_abort_tx_busy_done", k),
                                  {tx_w[k], busy_w[k], done_w[k]}, 3'b100);
                            aborted = 1'b1;
                            break;
                        end
                        expb = (i < dcyc) ? e.bits[i / e.bitcyc] : 1'b1;
                        if (tx_w[k] !== expb || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0)
                            slot_ok = 1'b0;
                        if ((i < dcyc && (i % e.bitcyc) == e.bitcyc - 1) || i == total - 1) begin
                            slot = (i < dcyc) ? i / e.bitcyc : e.nslots;
                            check(slot_ok, $sformatf("i%0d_slot%0d", k, slot),
                                  {31'd0, ~slot_ok}, 0);
                            slot_ok = 1'b1;
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check(done_w[k] === 1'b1 && busy_w[k] === 1'b0 && tx_w[k] === 1'b1,
                              $sformatf("i%0d_done_cycle", k),
                              {done_w[k], busy_w[k], tx_w[k]}, 3'b101);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    // Wait for a tick-aligned cycle so every slot is exactly 16*per cycles.
    task automatic send(input int k, input logic [7:0] d, input exp_t e);
        int n = 0;
        while (s_tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        sb.push_back(e);
        tx_data    = d;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int bound);
        int n = 0;
        while (done_w[k] !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        check(done_w[k] === 1'b1, $sformatf("i%0d_done_within_%0d", k, bound), n, bound);
    endtask

    function automatic exp_t mk(input int k, input logic [15:0] b, input int ns,
                                input int bc, input int sc, input int cut);
        exp_t e;
        e.inst = k; e.bits = b; e.nslots = ns; e.bitcyc = bc; e.stopcyc = sc; e.cut = cut;
        return e;
    endfunction

    initial begin
        int n;
        reset   = 1'b1;
        tx_data = 8'h00;
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;

        // Reset held 3 cycles with tx_start toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check(tx_w[k] === 1'b1 && busy_w[k] === 1'b0 && done_w[k] === 1'b0,
                      $sformatf("i%0d_reset_c%0d", k, i),
                      {tx_w[k], busy_w[k], done_w[k]}, 3'b100);
            tx_data = 8'hFF;
            for (int k = 0; k < 3; k++) start_v[k] = (i % 2 == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        repeat (3) @(negedge clk);

        // 0xA5, tick every cycle: line 0,1,0,1,0,0,1,0,1 then stop.
        send(0, 8'hA5, mk(0, 16'b1_0100_1010, 9, 16, 16, -1));
        wait_done(0, 400);
        repeat (5) @(negedge clk);

        // 0x3C, tick every 4th cycle; a mid-frame 0xFF request is ignored.
        per = 4;
        repeat (8) @(negedge clk);
        send(0, 8'h3C, mk(0, 16'b0_0111_1000, 9, 64, 64, -1));
        repeat (200) @(negedge clk);
        tx_data    = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 1200);
        per = 1;
        repeat (8) @(negedge clk);

        // Back-to-back: 0x0F then 0x55 requested in the done cycle.
        send(0, 8'h0F, mk(0, 16'b0_0001_1110, 9, 16, 16, -1));
        wait_done(0, 400);
        sb.push_back(mk(0, 16'b0_1010_1010, 9, 16, 16, -1));
        tx_data    = 8'h55;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check(tx_w[0] === 1'b0 && busy_w[0] === 1'b1, "b2b_start_next_cycle",
              {tx_w[0], busy_w[0]}, 2'b01);
        wait_done(0, 400);
        repeat (5) @(negedge clk);

        // 0x07 with parity and 32-tick stop: even -> 1, odd -> 0.
        send(1, 8'h07, mk(1, 16'b10_0000_1110, 10, 16, 32, -1));
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        send(2, 8'h07, mk(2, 16'b00_0000_1110, 10, 16, 32, -1));
        wait_done(2, 400);
        repeat (5) @(negedge clk);

        // Reset during data bit 3 of 0x81 (slot 4 covers cycles 64..79).
        send(0, 8'h81, mk(0, 16'b1_0000_0010, 9, 16, 16, 73));
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (72) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check(tx_w[0] === 1'b1 && busy_w[0] === 1'b0 && done_w[0] === 1'b0,
              "reset_midframe", {tx_w[0], busy_w[0], done_w[0]}, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        send(0, 8'h81, mk(0, 16'b1_0000_0010, 9, 16, 16, -1));
        wait_done(0, 400);
        repeat (20) @(negedge clk);

        check(ndone[0] == 5, "done_count_i0", ndone[0], 5);
        check(ndone[1] == 1, "done_count_i1", ndone[1], 1);
        check(ndone[2] == 1, "done_count_i2", ndone[2], 1);
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
